// File: rtl/ice_sl_arbiter_pkg.sv
// Shared definitions for the ICE slave-bus arbiter: FSM encodings, policy codes and width helpers.
package ice_sl_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Index/counter widths never collapse to zero bits, even for a single device or disabled watchdog.
  function automatic int width_of(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/ice_sl_arbiter_rr_pick.sv
// Combinational picker: first set bit of eligible_i at or after the start index, wrapping to 0.
// Fixed-priority mode forces the start index to 0, giving lowest-index-wins.
module ice_rr_pick
  import ice_sl_arbiter_pkg::*;
#(
  parameter int NUM_DEV = 7,
  localparam int IDX_W = width_of(NUM_DEV)
)(
  input  logic [NUM_DEV-1:0] eligible_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  input  logic               rr_mode_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               found_o
);

  localparam logic [IDX_W:0] NUM_DEV_W = NUM_DEV[IDX_W:0];

  logic [IDX_W-1:0]   start;
  logic [NUM_DEV-1:0] rotated;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     sum;

  always_comb begin
    start   = (rr_mode_i == ARB_MODE_RR) ? rr_ptr_i : '0;
    rotated = NUM_DEV'({eligible_i, eligible_i} >> start);
    offset  = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (rotated[i]) offset = i[IDX_W-1:0];
    end
    sum      = {1'b0, start} + {1'b0, offset};
    winner_o = (sum >= NUM_DEV_W) ? IDX_W'(sum - NUM_DEV_W) : IDX_W'(sum);
    found_o  = |eligible_i;
  end

endmodule

// File: rtl/ice_sl_arbiter.sv
// ICE slave-bus arbiter: grants sl_data ownership by fixed or round-robin policy, with masking and hold watchdog.
// state       | meaning
// ARB_IDLE    | no owner; grant the picked eligible device when the bus controller is ready
// ARB_GRANT   | one device owns the bus until tail, request drop or watchdog expiry
// ARB_RELEASE | one forced bus-idle cycle; round-robin pointer advances past the last owner
module ice_sl_arbiter
  import ice_sl_arbiter_pkg::*;
#(
  parameter int NUM_DEV  = 7,
  parameter int MAX_HOLD = 4096,
  localparam int IDX_W  = width_of(NUM_DEV),
  localparam int HOLD_W = width_of(MAX_HOLD + 1)
)(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               rr_mode_i,
  input  logic [NUM_DEV-1:0] req_mask_i,
  input  logic               ds_ready_i,
  input  logic [NUM_DEV-1:0] sl_arb_request_i,
  input  logic               sl_latch_tail_i,
  output logic [NUM_DEV-1:0] sl_arb_grant_o,
  output logic               grant_valid_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               timeout_o,
  output logic               abort_o,
  output logic [IDX_W-1:0]   event_idx_o
);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0]  LAST_DEV  = IDX_W'(NUM_DEV - 1);
  localparam bit                WDOG_EN   = (MAX_HOLD != 0);

  arb_state_e         state_q;
  logic [NUM_DEV-1:0] grant_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [IDX_W-1:0]   event_idx_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic [HOLD_W-1:0]  hold_q;
  logic               timeout_q;
  logic               abort_q;

  logic [NUM_DEV-1:0] eligible;
  logic [IDX_W-1:0]   winner;
  logic               found;

  assign eligible = sl_arb_request_i & ~req_mask_i;
  assign rr_ptr_d = (grant_idx_q == LAST_DEV) ? '0 : grant_idx_q + IDX_W'(1);

  ice_rr_pick #(.NUM_DEV(NUM_DEV)) u_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .rr_mode_i  (rr_mode_i),
    .winner_o   (winner),
    .found_o    (found)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      event_idx_q <= '0;
      rr_ptr_q    <= '0;
      hold_q      <= '0;
      timeout_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      abort_q   <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (ds_ready_i && found) begin
            grant_q     <= NUM_DEV'(1) << winner;
            grant_idx_q <= winner;
            hold_q      <= '0;
            state_q     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (hold_q != HOLD_MAX) hold_q <= hold_q + HOLD_W'(1);
          // Release causes are prioritised so at most one of abort/timeout can pulse.
          if (sl_latch_tail_i) begin
            grant_q <= '0;
            state_q <= ARB_RELEASE;
          end else if (!sl_arb_request_i[grant_idx_q]) begin
            abort_q     <= 1'b1;
            event_idx_q <= grant_idx_q;
            grant_q     <= '0;
            state_q     <= ARB_RELEASE;
          end else if (WDOG_EN && hold_q == HOLD_LAST) begin
            timeout_q   <= 1'b1;
            event_idx_q <= grant_idx_q;
            grant_q     <= '0;
            state_q     <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ARB_IDLE;
        end
        default: begin
          grant_q <= '0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign sl_arb_grant_o = grant_q;
  assign grant_valid_o  = |grant_q;
  assign grant_idx_o    = grant_idx_q;
  assign timeout_o      = timeout_q;
  assign abort_o        = abort_q;
  assign event_idx_o    = event_idx_q;

endmodule

// File: tb/tb_ice_sl_arbiter.sv
// Bench for ice_sl_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_ice_sl_arbiter;

  localparam int N  = 7;
  localparam int MH = 16;
  localparam int IW = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         rr_mode = 1'b0;
  logic         ds_ready = 1'b0;
  logic         tail = 1'b0;
  logic [N-1:0] mask = '0;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic         valid;
  logic         timeout;
  logic         abort;
  logic [IW-1:0] gidx;
  logic [IW-1:0] eidx;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_owner;
  int m_hold;
  int m_ptr;
  int m_last;
  int m_event;
  bit m_gap;
  bit m_timeout;
  bit m_abort;

  ice_sl_arbiter #(.NUM_DEV(N), .MAX_HOLD(MH)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .rr_mode_i        (rr_mode),
    .req_mask_i       (mask),
    .ds_ready_i       (ds_ready),
    .sl_arb_request_i (req),
    .sl_latch_tail_i  (tail),
    .sl_arb_grant_o   (grant),
    .grant_valid_o    (valid),
    .grant_idx_o      (gidx),
    .timeout_o        (timeout),
    .abort_o          (abort),
    .event_idx_o      (eidx)
  );

  always #5 clk = ~clk;

  function automatic int m_pick(input logic [N-1:0] e, input logic rr, input int ptr);
    int start;
    start = rr ? ptr : 0;
    for (int k = 0; k < N; k++) begin
      int d;
      d = (start + k) % N;
      if (e[d]) return d;
    end
    return -1;
  endfunction

  function automatic void m_reset();
    m_owner = -1; m_hold = 0; m_ptr = 0; m_last = 0; m_event = 0;
    m_gap = 1'b0; m_timeout = 1'b0; m_abort = 1'b0;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  function automatic void m_step();
    logic [N-1:0] e;
    e = req & ~mask;
    m_timeout = 1'b0;
    m_abort   = 1'b0;
    if (m_owner >= 0) begin
      if (tail || !req[m_owner] || m_hold == MH - 1) begin
        if (!tail && !req[m_owner]) begin
          m_abort = 1'b1; m_event = m_owner;
        end else if (!tail) begin
          m_timeout = 1'b1; m_event = m_owner;
        end
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_hold++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (ds_ready && e != '0) begin
      m_owner = m_pick(e, rr_mode, m_ptr);
      m_last  = m_owner;
      m_hold  = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    rr_mode = 1'b0; ds_ready = 1'b0; tail = 1'b0; mask = '0; req = '0;
    tick();
    tick();
    reset = 1'b0;
    m_reset();
  endtask

  task automatic wait_grant(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid === 1'b1) begin
        cyc = i + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_checks++;
    if (grant !== '0 || valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_grant: grant=%b valid=%b expected 0", grant, valid);
    end
    n_checks++;
    if (timeout !== 1'b0 || abort !== 1'b0) begin
      n_errors++; $display("FAIL reset_pulses: timeout=%b abort=%b expected 0", timeout, abort);
    end
    n_checks++;
    if (gidx !== '0 || eidx !== '0) begin
      n_errors++; $display("FAIL reset_idx: grant_idx=%0d event_idx=%0d expected 0", gidx, eidx);
    end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    rr_mode = 1'b0; ds_ready = 1'b1; req = 7'b0000110;
    tick();
    n_checks++;
    if (grant !== 7'b0000010 || gidx !== 3'd1) begin
      n_errors++; $display("FAIL fixed_first: grant=%b idx=%0d expected 0000010 idx 1", grant, gidx);
    end
    tail = 1'b1;
    tick();
    tail = 1'b0; req = 7'b0000100;
    n_checks++;
    if (grant !== '0) begin
      n_errors++; $display("FAIL fixed_release: grant=%b expected 0", grant);
    end
    tick();
    n_checks++;
    if (grant !== '0) begin
      n_errors++; $display("FAIL fixed_gap: grant=%b expected 0", grant);
    end
    tick();
    n_checks++;
    if (grant !== 7'b0000100 || gidx !== 3'd2) begin
      n_errors++; $display("FAIL fixed_second: grant=%b idx=%0d expected 0000100 idx 2", grant, gidx);
    end
    tail = 1'b1;
    tick();
    tail = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int cyc;
    int exp_seq[14] = '{0, 1, 2, 3, 4, 5, 6, 0, 1, 2, 3, 4, 0, 3};
    apply_reset();
    rr_mode = 1'b1; ds_ready = 1'b1; req = '1;
    for (int k = 0; k < 14; k++) begin
      wait_grant(8, cyc);
      n_checks++;
      if (cyc < 0 || gidx !== IW'(exp_seq[k]) || grant !== (N'(1) << exp_seq[k])) begin
        n_errors++;
        $display("FAIL rr_seq[%0d]: idx=%0d grant=%b wait=%0d expected idx %0d", k, gidx, grant, cyc, exp_seq[k]);
      end
      tick();
      tick();
      tail = 1'b1;
      if (k == 11) req = 7'b0001001;
      tick();
      tail = 1'b0;
      n_checks++;
      if (abort !== 1'b0 || valid !== 1'b0) begin
        n_errors++; $display("FAIL rr_tail_release[%0d]: abort=%b valid=%b expected 0 0", k, abort, valid);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_watchdog();
    int cyc;
    apply_reset();
    rr_mode = 1'b0; ds_ready = 1'b1; req = 7'b0100000;
    wait_grant(4, cyc);
    n_checks++;
    if (cyc < 0 || gidx !== 3'd5) begin
      n_errors++; $display("FAIL wdog_grant: idx=%0d wait=%0d expected idx 5", gidx, cyc);
    end
    for (int c = 2; c <= MH; c++) begin
      tick();
      n_checks++;
      if (timeout !== 1'b0 || grant !== 7'b0100000) begin
        n_errors++; $display("FAIL wdog_hold[%0d]: timeout=%b grant=%b expected 0 0100000", c, timeout, grant);
      end
    end
    tick();
    n_checks++;
    if (timeout !== 1'b1 || abort !== 1'b0 || eidx !== 3'd5 || grant !== '0) begin
      n_errors++;
      $display("FAIL wdog_expire: timeout=%b abort=%b event=%0d grant=%b expected 1 0 5 0", timeout, abort, eidx, grant);
    end
    tick();
    n_checks++;
    if (timeout !== 1'b0 || grant !== '0) begin
      n_errors++; $display("FAIL wdog_pulse_width: timeout=%b grant=%b expected 0 0", timeout, grant);
    end
    tick();
    n_checks++;
    if (grant !== 7'b0100000) begin
      n_errors++; $display("FAIL wdog_regrant: grant=%b expected 0100000", grant);
    end
    req = '0;
    tick();
  endtask

  task automatic test_abort();
    int cyc;
    apply_reset();
    rr_mode = 1'b0; ds_ready = 1'b1; req = 7'b0000100;
    wait_grant(4, cyc);
    tick(); tick(); tick();
    req = '0;
    tick();
    n_checks++;
    if (abort !== 1'b1 || timeout !== 1'b0 || eidx !== 3'd2 || grant !== '0) begin
      n_errors++;
      $display("FAIL abort_pulse: abort=%b timeout=%b event=%0d grant=%b expected 1 0 2 0", abort, timeout, eidx, grant);
    end
    tick();
    n_checks++;
    if (abort !== 1'b0) begin
      n_errors++; $display("FAIL abort_width: abort=%b expected 0", abort);
    end
    req = 7'b0000100;
    wait_grant(6, cyc);
    n_checks++;
    if (cyc < 0 || gidx !== 3'd2) begin
      n_errors++; $display("FAIL abort_regrant: idx=%0d wait=%0d expected idx 2", gidx, cyc);
    end
    tick(); tick(); tick();
    req = '0; tail = 1'b1;
    tick();
    tail = 1'b0;
    n_checks++;
    if (abort !== 1'b0 || grant !== '0) begin
      n_errors++; $display("FAIL abort_coincide: abort=%b grant=%b expected 0 0", abort, grant);
    end
    tick();
  endtask

  task automatic test_mask_ready();
    apply_reset();
    rr_mode = 1'b0; ds_ready = 1'b0; mask = 7'b0000001; req = 7'b0001001;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (grant !== '0) begin
        n_errors++; $display("FAIL ready_gate[%0d]: grant=%b expected 0", c, grant);
      end
    end
    ds_ready = 1'b1;
    tick();
    n_checks++;
    if (grant !== 7'b0001000 || gidx !== 3'd3) begin
      n_errors++; $display("FAIL mask_grant: grant=%b idx=%0d expected 0001000 idx 3", grant, gidx);
    end
    mask = 7'b0001000; rr_mode = 1'b1; ds_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (grant !== 7'b0001000) begin
        n_errors++; $display("FAIL mask_hold[%0d]: grant=%b expected 0001000", c, grant);
      end
    end
    tail = 1'b1;
    tick();
    tail = 1'b0; mask = '0; req = '0;
    n_checks++;
    if (grant !== '0) begin
      n_errors++; $display("FAIL mask_release: grant=%b expected 0", grant);
    end
    tick();
  endtask

  task automatic test_reset_mid_grant();
    int cyc;
    apply_reset();
    rr_mode = 1'b1; ds_ready = 1'b1; req = 7'b0000100;
    wait_grant(4, cyc);
    tail = 1'b1; req = '1;
    tick();
    tail = 1'b0;
    wait_grant(4, cyc);
    n_checks++;
    if (cyc < 0 || gidx !== 3'd3) begin
      n_errors++; $display("FAIL rst_setup: idx=%0d wait=%0d expected idx 3", gidx, cyc);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (grant !== '0 || valid !== 1'b0 || timeout !== 1'b0 || abort !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_async: grant=%b valid=%b timeout=%b abort=%b expected all 0", grant, valid, timeout, abort);
    end
    #2;
    reset = 1'b0;
    tick();
    n_checks++;
    if (grant !== 7'b0000001 || gidx !== 3'd0) begin
      n_errors++; $display("FAIL rst_ptr: grant=%b idx=%0d expected 0000001 idx 0", grant, gidx);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_grant;
    logic         exp_valid;
    apply_reset();
    ds_ready = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) rr_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) mask = N'($urandom) & N'($urandom);
      ds_ready = ($urandom_range(0, 4) != 0);
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 19) == 0) req[d] = ~req[d];
      end
      tail = ($urandom_range(0, 23) == 0);
      m_step();
      tick();
      exp_valid = (m_owner >= 0);
      exp_grant = exp_valid ? (N'(1) << m_owner) : '0;
      n_checks++;
      if (grant !== exp_grant || valid !== exp_valid) begin
        n_errors++;
        if (n_errors < 20) $display("FAIL rand_grant@%0d: grant=%b valid=%b expected %b %b", c, grant, valid, exp_grant, exp_valid);
      end
      n_checks++;
      if (gidx !== IW'(m_last)) begin
        n_errors++;
        if (n_errors < 20) $display("FAIL rand_idx@%0d: idx=%0d expected %0d", c, gidx, m_last);
      end
      n_checks++;
      if (timeout !== m_timeout || abort !== m_abort || eidx !== IW'(m_event)) begin
        n_errors++;
        if (n_errors < 20)
          $display("FAIL rand_event@%0d: timeout=%b abort=%b event=%0d expected %b %b %0d",
                   c, timeout, abort, eidx, m_timeout, m_abort, m_event);
      end
    end
    tail = 1'b0;
  endtask

  initial begin
    m_reset();
    #1;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_watchdog();
    test_abort();
    test_mask_ready();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
